// File: rtl/list_walk_pkg.sv
// list_walk_pkg: shared definitions for the linked-list walker.
//   - reduction mode encodings (2-bit mode port)
//   - FSM state enum
//   - pointer-width helper derived from the node-memory depth
package list_walk_pkg;

  localparam logic [1:0] MODE_SUM   = 2'b00;
  localparam logic [1:0] MODE_COUNT = 2'b01;
  localparam logic [1:0] MODE_MAX   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Pointer width for a node memory of 'depth' entries (depth >= 2).
  function automatic int calc_aw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/list_node_ram.sv
// list_node_ram: DEPTH x DW synchronous RAM, one write port, one read port.
//   clk      : clock
//   we       : write strobe (gated by the caller)
//   waddr    : write address
//   wdata    : write word {next, value}
//   raddr    : read address
//   rdata_q  : registered read data, one cycle after raddr
// Contents are not reset. A read of the address being written in the same
// cycle returns the old word.
module list_node_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_q
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

endmodule

// File: rtl/list_walk_accum.sv
// list_walk_accum: walks a linked list held in an internal node memory,
// starting at start_addr and following next pointers until a null (0)
// pointer, reducing node values in SUM / COUNT / MAX mode.
//   clk, rst            : clock, asynchronous active-low reset
//   step_en             : advance tick; READ/ACC only move when it is 1
//   wr_en/addr/value/next : node write port (accepted only when not busy)
//   start, start_addr   : begin a walk (ignored while busy); head 0 = empty
//   mode                : 00 SUM, 01 COUNT, 10 MAX, 11 SUM
//   busy, done          : walk in progress / result valid (level)
//   result, ovf         : reduction result, sticky saturation flag
//   err                 : loop-guard abort
// Optional build macro LIST_WALK_LOOPGUARD_EN: aborts a walk once DEPTH
// nodes have been visited without reaching a null pointer. Without it there
// is no hop counter and err is constant 0.
module list_walk_accum
  import list_walk_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = calc_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_en,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_value,
  input  logic [AW-1:0] wr_next,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [1:0]    mode,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          ovf,
  output logic          err
);

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] cur_ptr_q, cur_ptr_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
`ifdef LIST_WALK_LOOPGUARD_EN
  logic [AW-1:0] hops_q, hops_d;
  logic          err_q, err_d;
`endif

  logic          idle_like;
  logic [W+AW-1:0] rd_data;
  logic [W-1:0]  node_value;
  logic [AW-1:0] node_next;
  logic [W:0]    add_w;
  logic [W-1:0]  red_val;
  logic          red_sat;

  assign idle_like = (state_q == IDLE) || (state_q == DONE);

  // Read address is always the current pointer, so the registered read
  // data stays valid however long READ/ACC are stalled by step_en.
  list_node_ram #(.DEPTH(DEPTH), .AW(AW), .DW(W + AW)) u_ram (
    .clk     (clk),
    .we      (wr_en && idle_like),
    .waddr   (wr_addr),
    .wdata   ({wr_next, wr_value}),
    .raddr   (cur_ptr_q),
    .rdata_q (rd_data)
  );

  assign node_value = rd_data[W-1:0];
  assign node_next  = rd_data[W+AW-1:W];

  // Reduction of the current node into the running result.
  always_comb begin
    add_w   = {1'b0, result_q} +
              ((mode_q == MODE_COUNT) ? (W+1)'(1) : {1'b0, node_value});
    red_val = result_q;
    red_sat = 1'b0;
    if (mode_q == MODE_MAX) begin
      red_val = (node_value > result_q) ? node_value : result_q;
    end else if (add_w[W]) begin
      red_val = '1;
      red_sat = 1'b1;
    end else begin
      red_val = add_w[W-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cur_ptr_d = cur_ptr_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
`ifdef LIST_WALK_LOOPGUARD_EN
    hops_d    = hops_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mode_d    = mode;
          cur_ptr_d = start_addr;
          result_d  = '0;
          ovf_d     = 1'b0;
`ifdef LIST_WALK_LOOPGUARD_EN
          hops_d    = '0;
          err_d     = 1'b0;
`endif
          state_d   = (start_addr == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (step_en) state_d = ACC;
      end
      ACC: begin
        if (step_en) begin
          result_d  = red_val;
          ovf_d     = ovf_q | red_sat;
          cur_ptr_d = node_next;
`ifdef LIST_WALK_LOOPGUARD_EN
          hops_d    = hops_q + AW'(1);
          if (node_next == '0) begin
            state_d = DONE;
          end else if (hops_q == AW'(DEPTH - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = READ;
          end
`else
          state_d   = (node_next == '0) ? DONE : READ;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mode_q    <= MODE_SUM;
      cur_ptr_q <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
`ifdef LIST_WALK_LOOPGUARD_EN
      hops_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cur_ptr_q <= cur_ptr_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
`ifdef LIST_WALK_LOOPGUARD_EN
      hops_q    <= hops_d;
      err_q     <= err_d;
`endif
    end
  end

  assign busy   = (state_q == READ) || (state_q == ACC);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign ovf    = ovf_q;
`ifdef LIST_WALK_LOOPGUARD_EN
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_list_walk_accum.sv
// tb_list_walk_accum: scoreboard bench for list_walk_accum (W=8, DEPTH=16).
// Expected results are pushed when a walk is started and popped when done
// rises. The cyclic-list case follows LIST_WALK_LOOPGUARD_EN.
module tb_list_walk_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       step_en = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_value = '0;
  logic [3:0] wr_next = '0;
  logic       start = 1'b0;
  logic [3:0] start_addr = '0;
  logic [1:0] mode = '0;
  logic       busy, done, ovf, err;
  logic [7:0] result;

  typedef struct {
    logic [7:0] result;
    logic       ovf;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  list_walk_accum #(.W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .step_en(step_en), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_value(wr_value), .wr_next(wr_next),
    .start(start), .start_addr(start_addr), .mode(mode),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_node(input logic [3:0] a, input logic [7:0] v, input logic [3:0] n);
    wr_en = 1'b1; wr_addr = a; wr_value = v; wr_next = n;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Drive a one-cycle start and push the expected outcome.
  task automatic start_walk(input logic [3:0] head, input logic [1:0] md,
                            input logic [7:0] r, input logic o, input logic e);
    exp_t x;
    x.result = r; x.ovf = o; x.err = e;
    sb.push_back(x);
    start = 1'b1; start_addr = head; mode = md;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
  endtask

  // Clock until done, pulsing step_en every 'period' cycles; optionally
  // inject a start and a node write while busy. Compare against the
  // scoreboard. exp_cyc / exp_steps < 0 skips that comparison.
  task automatic finish_walk(input string tag, input int period, input bit inject,
                             input int exp_cyc, input int exp_steps);
    int cyc = 0;
    int steps = 0;
    bit saw_busy = 1'b0;
    exp_t x;
    while (!done && cyc < 2000) begin
      saw_busy = saw_busy | busy;
      step_en = (period == 1) || (cyc % period == period - 1);
      if (inject && cyc == 1) begin
        start = 1'b1; start_addr = 4'd1; mode = 2'b01;
        wr_en = 1'b1; wr_addr = 4'd2; wr_value = 8'd99; wr_next = 4'd0;
      end
      if (step_en && busy) steps++;
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
      cyc++;
    end
    step_en = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
    if (exp_cyc >= 0) check({tag, "_cycles"}, cyc, exp_cyc);
    if (exp_steps >= 0) check({tag, "_steps"}, steps, exp_steps);
    if (exp_cyc == 0) check({tag, "_never_busy"}, saw_busy, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      x = sb.pop_front();
      check({tag, "_result"}, result, x.result);
      check({tag, "_ovf"}, ovf, x.ovf);
      check({tag, "_err"}, err, x.err);
    end
  endtask

  initial begin
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    write_node(4'd3, 8'd5, 4'd7);
    write_node(4'd7, 8'd10, 4'd2);
    write_node(4'd2, 8'd20, 4'd0);

    start_walk(4'd3, 2'b00, 8'd35, 1'b0, 1'b0);
    finish_walk("sum3", 1, 1'b0, 6, 6);
    start_walk(4'd3, 2'b01, 8'd3, 1'b0, 1'b0);
    finish_walk("count3", 1, 1'b0, 6, -1);
    start_walk(4'd3, 2'b10, 8'd20, 1'b0, 1'b0);
    finish_walk("max3", 1, 1'b0, 6, -1);
    start_walk(4'd3, 2'b11, 8'd35, 1'b0, 1'b0);
    finish_walk("mode11", 1, 1'b0, 6, -1);

    write_node(4'd1, 8'd200, 4'd4);
    write_node(4'd4, 8'd100, 4'd0);
    start_walk(4'd1, 2'b00, 8'd255, 1'b1, 1'b0);
    finish_walk("sat", 1, 1'b0, 4, -1);
    start_walk(4'd1, 2'b10, 8'd200, 1'b0, 1'b0);
    finish_walk("max_ovf_clr", 1, 1'b0, 4, -1);

    start_walk(4'd0, 2'b00, 8'd0, 1'b0, 1'b0);
    finish_walk("empty", 1, 1'b0, 0, 0);

    // Sparse step_en plus ignored mid-walk start/write (node 2 -> 99 would give 114).
    start_walk(4'd3, 2'b00, 8'd35, 1'b0, 1'b0);
    finish_walk("slow", 4, 1'b1, -1, 6);
    start_walk(4'd3, 2'b00, 8'd35, 1'b0, 1'b0);
    finish_walk("mem_kept", 1, 1'b0, 6, -1);

    // Write and start in the same idle cycle: the walk sees the new node.
    wr_en = 1'b1; wr_addr = 4'd5; wr_value = 8'd7; wr_next = 4'd0;
    start_walk(4'd5, 2'b00, 8'd7, 1'b0, 1'b0);
    finish_walk("wr_start", 1, 1'b0, 2, -1);

    // Cyclic list 1 <-> 2.
    write_node(4'd1, 8'd1, 4'd2);
    write_node(4'd2, 8'd1, 4'd1);
`ifdef LIST_WALK_LOOPGUARD_EN
    start_walk(4'd1, 2'b00, 8'd16, 1'b0, 1'b1);
    finish_walk("loopguard", 1, 1'b0, 32, 32);
`else
    start = 1'b1; start_addr = 4'd1; mode = 2'b00;
    @(posedge clk); #1;
    start = 1'b0; step_en = 1'b1;
    repeat (200) @(posedge clk);
    #3;
    check("cyc_busy", busy, 1);
    check("cyc_done", done, 0);
    check("cyc_err", err, 0);
    rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_result", result, 0);
    check("arst_ovf", ovf, 0);
    step_en = 1'b0;
    @(negedge clk); rst = 1'b1;
`endif
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/list_walk_accum.md
Name: list_walk_accum

Overview:
- Parametrised linked-list walker/accumulator: successor to the fixed 8-bit sum engine.
- Holds a node memory of DEPTH entries, each a value plus a next pointer; follows pointers from a start address until it reads a null pointer (0).
- Reduces visited values in SUM, COUNT or MAX mode.
- Runs on one clock with a step-enable tick instead of a divided clock. Result and done feed the display and LED logic.

Parameters:
- W, 8, data/result width in bits.
- DEPTH, 16, node memory entries; power of two, at least 2.
- AW, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- step_en  in  1  advance tick; the FSM advances only on cycles where it is 1
- wr_en  in  1  node write strobe
- wr_addr  in  AW  node write address
- wr_value  in  W  node value
- wr_next  in  AW  node next pointer
- start  in  1  one-cycle start request
- start_addr  in  AW  head pointer; 0 means empty list
- mode  in  2  00 SUM, 01 COUNT, 10 MAX, 11 treated as SUM
- busy  out  1  walk in progress
- done  out  1  level; result valid
- result  out  W  reduction result
- ovf  out  1  sticky saturation flag for current run
- err  out  1  loop-guard abort (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, result=0, ovf=0, err=0, pointer and hop count 0. Memory contents are not reset.
- Memory: entry = {next[AW-1:0], value[W-1:0]}. Synchronous write and synchronous read with 1-cycle read latency.
- States: IDLE, READ, ACC, DONE.
- IDLE/DONE, on start=1 (step_en not required):
  - latch mode and start_addr; clear result/ovf/err/hops; drop done.
  - if start_addr==0, go DONE with result=0; done rises the next cycle.
  - otherwise go READ; busy=1.
- READ: drive read address = cur_ptr. On step_en=1 go ACC; otherwise hold and keep the read address stable.
- ACC: read data is valid. On step_en=1:
  - SUM: result = result + value; saturates at 2^W-1 and sets ovf.
  - COUNT: result = result + 1; saturates the same way and sets ovf.
  - MAX: result = max(result, value), unsigned.
  - cur_ptr = next; hops = hops + 1.
  - If next==0 go DONE, else go READ.
- With step_en held at 1, each node costs 2 cycles; done=1 and busy=0 on the cycle after the final ACC.
- DONE: done=1 and result held until the next accepted start.
- start while busy: ignored.
- wr_en while busy: ignored, so memory cannot change mid-walk. wr_en in IDLE/DONE: accepted.
- wr_en and start in the same cycle in IDLE: both accepted. The first READ happens one cycle later and sees the new data.
- A pointer to address 0 inside a list always terminates, so node 0 is never visited.
- Reset asserted mid-walk aborts immediately to reset values.

Optional Feature:
- Macro LIST_WALK_LOOPGUARD_EN.
- Defined: in ACC, if hops+1 == DEPTH and next != 0, the walk aborts to DONE with err=1. result holds the value including that node; done=1.
- Undefined: no hop limit; a cyclic list walks forever (busy stays 1 until reset); err is tied to 0 and the hop counter is removed.

Decomposition:
- Shared package list_walk_pkg:
  - mode encodings MODE_SUM/MODE_COUNT/MODE_MAX;
  - state enum IDLE/READ/ACC/DONE;
  - function computing AW from DEPTH.
- One sub-module, list_node_ram: DEPTH x (W+AW) synchronous RAM with a 1-cycle read and write port. Keeps memory inference separate from the FSM/datapath.

Test Plan:
- Write nodes 3:{val=5,next=7}, 7:{val=10,next=2}, 2:{val=20,next=0}; start_addr=3, SUM, step_en=1 -> done after 6 cycles, result=35, ovf=0.
- Same list in COUNT -> result=3; in MAX -> result=20.
- W=8, nodes 1:{200,next=4}, 4:{100,next=0}, SUM -> result=255, ovf=1, done=1.
- start_addr=0 -> done the next cycle, result=0, busy never asserted.
- step_en pulsed every 4th cycle on the 3-node list -> same result 35, 6 enabled steps. start and wr_en asserted mid-walk -> both ignored, result unchanged.
- LIST_WALK_LOOPGUARD_EN defined, DEPTH=16, nodes 1:{1,next=2}, 2:{1,next=1} -> after 16 node visits err=1, done=1, result=16. Macro undefined -> busy stays 1; assert rst=0 -> all outputs return to 0 at once.
